// File: rtl/seq_mem_engine.sv
// Sequential RAM sweep engine: reads or writes len+1 consecutive words
// starting at base, with address wrap and a one-cycle done pulse.
module seq_mem_engine #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          status,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          wr_valid,
  input  logic [DW-1:0] wdata,
  output logic          wr_ready,
  output logic [AW-1:0] addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_mode;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_len;
  logic [AW:0]   r_i;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_mem [2**AW];
  logic          w_last;
  logic          w_we;
  logic          w_re;

  assign addr     = r_base + r_i[AW-1:0];
  assign w_last   = (r_i == {1'b0, r_len});
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_we     = 1'b0;
    w_re     = 1'b0;
    wr_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = RUN;
      end
      RUN: begin
        if (r_mode) begin
          wr_ready = 1'b1;
          w_we     = wr_valid;
          if (wr_valid && w_last) w_next = DONE;
        end else begin
          w_re = 1'b1;
          if (w_last) w_next = DRAIN;
        end
      end
      DRAIN: w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Offset counter is one bit wider than the address so full depth terminates cleanly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_i        <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_re;
      if (w_re) r_rd_data <= r_mem[addr];
      if (r_state == IDLE && start) begin
        r_mode <= status;
        r_base <= base;
        r_len  <= len;
        r_i    <= '0;
      end else if (w_we || w_re) begin
        r_i <= r_i + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset so contents survive an abort
  always_ff @(posedge clk) begin
    if (w_we) r_mem[addr] <= wdata;
  end

endmodule
